// File: rtl/seven_segment_decoder.sv
// Recovers per-digit hex values from a multiplexed active-low seven-segment bus.
// Latency: STABLE_CYCLES+2 clk from stable pins to upd/digits; no backpressure (free-running sampler).
module seven_segment_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              s_sgmt,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   valid,
    output logic                    upd,
    output logic [1:0]              upd_idx,
    output logic                    seg_err
);
    localparam int              W      = NUM_DIGITS + 7;
    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [6:0]      BLANK  = 7'h7F;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 4) begin : g_bad_num_digits
        $error("seven_segment_decoder: NUM_DIGITS must be 1..4");
    end
    if (STABLE_CYCLES < 1 || (2 ** CNT_W) <= STABLE_CYCLES) begin : g_bad_stable
        $error("seven_segment_decoder: STABLE_CYCLES must be >=1 and fit in CNT_W");
    end

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURED
    } state_t;

    state_t                 state;
    logic [W-1:0]           sync1;
    logic [W-1:0]           smp;
    logic [W-1:0]           prv;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [NUM_DIGITS-1:0]  smp_an;
    logic [6:0]             smp_seg;
    logic                   changed;
    logic                   one_hot;
    logic [1:0]             idx;
    logic [4:0]             dec;
    logic                   legal;
    logic [3:0]             value;

    // Returns {legal, value} for an active-low segment pattern.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    assign smp_an  = smp[W-1:7];
    assign smp_seg = smp[6:0];
    assign changed = (smp != prv);
    assign one_hot = $onehot(~smp_an);
    assign dec     = decode(smp_seg);
    assign legal   = dec[4];
    assign value   = dec[3:0];

    always_comb begin
        cnt_nxt = cnt;
        if (changed) begin
            cnt_nxt = '0;
        end else if (cnt != STABLE) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!smp_an[i]) begin
                idx = 2'(i);
            end
        end
    end

    // Idle pins sample as all ones, i.e. no anode driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            smp   <= '1;
            prv   <= '1;
            cnt   <= '0;
        end else begin
            sync1 <= {an, s_sgmt};
            smp   <= sync1;
            prv   <= smp;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            digits  <= '0;
            valid   <= '0;
            upd     <= 1'b0;
            upd_idx <= 2'd0;
            seg_err <= 1'b0;
        end else begin
            upd     <= 1'b0;
            seg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (one_hot) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (changed) begin
                        state <= one_hot ? SETTLE : IDLE;
                    end else if (cnt_nxt == STABLE) begin
                        state <= CAPTURED;
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (idx == 2'(i)) begin
                                if (legal) begin
                                    digits[4*i +: 4] <= value;
                                end
                                valid[i] <= legal;
                            end
                        end
                        // A blank digit is a legitimate display state, not an error.
                        if (legal || smp_seg == BLANK) begin
                            upd     <= 1'b1;
                            upd_idx <= idx;
                        end else begin
                            seg_err <= 1'b1;
                        end
                    end
                end
                CAPTURED: begin
                    if (changed) begin
                        state <= one_hot ? SETTLE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seven_segment_decoder.sv
// Scoreboard bench: a pin pattern held STABLE+1 cycles with one anode low yields one capture, 2 edges later.
module tb_seven_segment_decoder;
    localparam int ND = 4;
    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [6:0]  s_sgmt = 7'h7F;
    logic [3:0]  an = 4'hF;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic        upd;
    logic [1:0]  upd_idx;
    logic        seg_err;

    seven_segment_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .s_sgmt(s_sgmt), .an(an),
        .digits(digits), .valid(valid), .upd(upd), .upd_idx(upd_idx), .seg_err(seg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [1:0]  idx;
        logic [15:0] dig;
        logic [3:0]  val;
        int          due;
    } ev_t;

    ev_t         sb[$];
    ev_t         me;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          run = 0;
    int          n_upd = 0;
    int          n_err = 0;
    logic [10:0] last_pins = '1;
    logic [15:0] mdig = '0;
    logic [3:0]  mval = '0;
    logic [15:0] shown_dig = '0;
    logic [3:0]  shown_val = '0;
    logic        prev_pulse = 1'b0;
    logic [6:0]  seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: capture outcome decided by table lookup of the held pattern.
    task automatic push(input logic [3:0] a, input logic [6:0] s);
        ev_t e;
        int  i = 0;
        int  v = -1;
        for (int k = 0; k < 4; k++) if (!a[k]) i = k;
        for (int k = 0; k < 16; k++) if (seg_tbl[k] == s) v = k;
        e.err = (v < 0) && (s != 7'h7F);
        e.idx = 2'(i);
        if (v >= 0) begin
            mdig[4*i +: 4] = 4'(v);
            mval[i] = 1'b1;
        end else begin
            mval[i] = 1'b0;
        end
        e.dig = mdig;
        e.val = mval;
        e.due = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic step(input logic [3:0] a, input logic [6:0] s);
        an = a;
        s_sgmt = s;
        @(posedge clk);
        #1;
        if (run > 0 && {a, s} == last_pins) run++;
        else run = 1;
        last_pins = {a, s};
        if (run == SC + 1 && $countones(~a) == 1) push(a, s);
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        repeat (n) step(a, s);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        chk("rst_now_digits", 32'(digits), 32'h0);
        chk("rst_now_valid", 32'(valid), 32'h0);
        sb.delete();
        run = 0;
        mdig = '0;
        mval = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_digits", 32'(digits), 32'h0);
            chk("rst_valid", 32'(valid), 32'h0);
            chk("rst_upd", 32'(upd), 32'h0);
            chk("rst_seg_err", 32'(seg_err), 32'h0);
            shown_dig = '0;
            shown_val = '0;
            prev_pulse = 1'b0;
        end else begin
            if (upd || seg_err) begin
                n_upd += int'(upd);
                n_err += int'(seg_err);
                chk("pulse_exclusive", 32'(upd && seg_err), 32'h0);
                chk("pulse_back_to_back", 32'(prev_pulse), 32'h0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: upd=%0b seg_err=%0b idx=%0d, expected no pulse (cycle %0d)",
                             upd, seg_err, upd_idx, cyc);
                end else begin
                    me = sb.pop_front();
                    chk("pulse_cycle", 32'(cyc), 32'(me.due));
                    chk("seg_err_kind", 32'(seg_err), 32'(me.err));
                    if (upd) chk("upd_idx", 32'(upd_idx), 32'(me.idx));
                    shown_dig = me.dig;
                    shown_val = me.val;
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                me = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_pulse: got none, expected %s idx=%0d (cycle %0d)",
                         me.err ? "seg_err" : "upd", me.idx, cyc);
                shown_dig = me.dig;
                shown_val = me.val;
            end
            chk("digits_hold", 32'(digits), 32'(shown_dig));
            chk("valid_hold", 32'(valid), 32'(shown_val));
            prev_pulse = upd || seg_err;
        end
    end

    initial begin
        int base;
        int k;
        logic [3:0] a;
        logic [6:0] s;
        @(posedge clk);
        #1;
        // Reset with a live digit on the pins.
        an = 4'b1110;
        s_sgmt = 7'h12;
        do_reset(4);
        // Single digit held.
        base = n_upd;
        hold(4'b1110, 7'h12, 10);
        chk("single_upd_count", 32'(n_upd - base), 32'd1);
        chk("single_digit0", 32'(digits[3:0]), 32'h5);
        chk("single_valid", 32'(valid), 32'b0001);
        // Two-digit mux scan.
        base = n_upd;
        for (int r = 0; r < 4; r++) begin
            hold(4'b1110, 7'h10, 8);
            hold(4'b1101, 7'h24, 8);
        end
        chk("scan_upd_count", 32'(n_upd - base), 32'd8);
        chk("scan_digits", 32'(digits[7:0]), 32'h29);
        chk("scan_valid", 32'(valid), 32'b0011);
        // Short glitch to '3' between two displays of '5'.
        hold(4'b1110, 7'h12, 8);
        base = n_upd;
        hold(4'b1110, 7'h30, 3);
        hold(4'b1110, 7'h12, 8);
        chk("glitch_upd_count", 32'(n_upd - base), 32'd1);
        chk("glitch_digit0", 32'(digits[3:0]), 32'h5);
        // Illegal pattern, then two anodes low.
        base = n_err;
        hold(4'b1110, 7'h7E, 8);
        chk("err_count", 32'(n_err - base), 32'd1);
        chk("err_valid0", 32'(valid[0]), 32'h0);
        chk("err_digit0_held", 32'(digits[3:0]), 32'h5);
        base = n_upd + n_err;
        hold(4'b1100, 7'h00, 8);
        chk("multi_anode_pulses", 32'(n_upd + n_err - base), 32'd0);
        // Reset while settling a new digit, then re-settle.
        hold(4'b1011, 7'h19, 5);
        do_reset(2);
        hold(4'b1011, 7'h19, 10);
        chk("post_reset_digit2", 32'(digits[11:8]), 32'h4);
        chk("post_reset_valid", 32'(valid), 32'b0100);
        // Randomised phases.
        for (int p = 0; p < 300; p++) begin
            k = $urandom_range(0, 99);
            if (k < 80) a = ~(4'b0001 << $urandom_range(0, 3));
            else a = 4'($urandom);
            k = $urandom_range(0, 99);
            if (k < 70) s = seg_tbl[$urandom_range(0, 15)];
            else if (k < 82) s = 7'h7F;
            else s = 7'($urandom);
            hold(a, s, $urandom_range(1, 12));
        end
        hold(4'hF, 7'h7F, 2);
        for (int t = 0; t < 20 && sb.size() > 0; t++) step(4'hF, 7'h7F);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("final_digits", 32'(digits), 32'(mdig));
        chk("final_valid", 32'(valid), 32'(mval));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
